text_buf_arbiter: RTL and testbench
===================================

TEXT_BUF_ARBITER -- requirements
Module: text_buf_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 The parameters SHALL be as follows:
- ADDR_W, default 12: character-cell address width.
- DATA_W, default 6: character code width (char_rom start-address code).
- CELLS, default 2400: number of screen cells (80x30).
- FIFO_DEPTH, default 4: keyboard write queue depth, a power of 2.
- BLANK, default 0: code written by a screen clear.
REQ-003 The ports SHALL be as follows:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- disp_req  in  1  display fetch request, real-time
- disp_addr  in  ADDR_W  cell to fetch
- disp_data  out  DATA_W  fetched code
- disp_valid  out  1  disp_data valid
- wr_valid  in  1  keyboard write offered
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high
- wr_addr  in  ADDR_W  write cell
- wr_data  in  DATA_W  write code
- clear_req  in  1  single-cycle pulse: blank the whole screen
- busy  out  1  clear in progress
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read

Function
REQ-004 A single-port RAM SHALL be shared, with at most one access per clk cycle.
REQ-005 Slot priority SHALL be, highest first: display read, clear write, FIFO write.
REQ-006 When disp_req=1, the block SHALL drive mem_en=1, mem_we=0 and mem_addr=disp_addr combinationally in the same cycle.
REQ-007 disp_valid SHALL be asserted exactly 1 cycle after an accepted disp_req, with disp_data=mem_rdata; otherwise disp_valid=0 and disp_data holds its last value.
REQ-008 wr_ready SHALL equal (FIFO not full) AND (state=IDLE).
REQ-009 The FIFO SHALL accept {wr_addr,wr_data} on a handshake.
REQ-010 A simultaneous push and pop on a full FIFO SHALL NOT be permitted, since wr_ready=0 when full.
REQ-011 A simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged.
REQ-012 In IDLE, in a cycle with disp_req=0 and the FIFO non-empty, the block SHALL pop the head and issue a RAM write.
REQ-013 Pops SHALL be in arrival order, with no reordering and no loss.
REQ-014 The FSM SHALL have two states, IDLE and CLEAR.
REQ-015 clear_req in IDLE SHALL, on the next cycle, enter CLEAR, flush the FIFO, set clr_addr=0 and set busy=1.
REQ-016 In CLEAR, each cycle with disp_req=0 SHALL write BLANK to clr_addr and increment clr_addr.
REQ-017 The write to clr_addr=CELLS-1 SHALL return the FSM to IDLE next cycle with busy=0; clr_addr SHALL never reach CELLS.
REQ-018 clear_req in CLEAR SHALL restart clr_addr at 0.
REQ-019 clear_req coincident with a wr handshake SHALL discard that write, because the flush wins.
REQ-020 Writes to an address of CELLS or greater SHALL be dropped: popped with mem_en=0.
REQ-021 Idle cycles SHALL have mem_en=0, mem_we=0, and mem_addr/mem_wdata=0.

Reset
REQ-022 On reset, the block SHALL set state=IDLE, the FIFO empty, clr_addr=0, busy=0, disp_valid=0, disp_data=0 and wr_ready=1 from the next cycle.
REQ-023 Reset mid-CLEAR or mid-drain SHALL abandon the operation; RAM contents are not restored.

Configuration
REQ-024 With macro TEXTBUF_CLEAR_EN defined, the CLEAR state and clr_addr counter SHALL be compiled in.
REQ-025 Without TEXTBUF_CLEAR_EN, clear_req SHALL be ignored, busy SHALL be tied 0, and the FSM SHALL stay in IDLE.

Structure
REQ-026 Package text_buf_pkg SHALL hold the ADDR_W/DATA_W/CELLS/BLANK defaults and the FSM state enum {IDLE, CLEAR}.
REQ-027 The FIFO SHALL be sub-module text_buf_fifo: synchronous, FIFO_DEPTH entries, with full/empty flags and push/pop ports.

Verification
REQ-028 Read latency: disp_req=1, disp_addr=5, RAM[5]=0x2A -> next cycle disp_valid=1, disp_data=0x2A.
REQ-029 Priority: disp_req held high 10 cycles while 3 writes are queued -> no mem_we during those cycles; the 3 writes then occur in the next 3 disp_req=0 cycles in order.
REQ-030 Full: 5 back-to-back wr_valid with disp_req=1 -> 4 accepted, wr_ready=0 on the 5th; first pop frees a slot.
REQ-031 Clear: clear_req with no display traffic -> busy=1 for 2400 cycles, RAM all BLANK, busy=0 on cycle 2401; with the macro undefined, no RAM change.
REQ-032 Clear restart/flush: 2 writes queued, then clear_req, then second clear_req at clr_addr=100 -> queued writes never reach RAM, clr_addr restarts at 0, total 2400 writes after restart.
REQ-033 Reset mid-clear at clr_addr=50 -> next cycle busy=0, wr_ready=1, disp_valid=0.

Source files
------------

// File: rtl/text_buf_pkg.sv
// text_buf_pkg: shared defaults and FSM state type for the text buffer arbiter.
//   ADDR_W_DEF/DATA_W_DEF/CELLS_DEF/FIFO_DEPTH_DEF/BLANK_DEF : parameter defaults
//   state_t : arbiter FSM states (IDLE, CLEAR)
package text_buf_pkg;
   localparam int ADDR_W_DEF     = 12;
   localparam int DATA_W_DEF     = 6;
   localparam int CELLS_DEF      = 2400;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int BLANK_DEF      = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;
endpackage

// File: rtl/text_buf_fifo.sv
// text_buf_fifo: synchronous FIFO holding pending keyboard writes {addr,data}.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   flush      : empties the queue (wins over push/pop)
//   push/wdata : enqueue (ignored when full)
//   pop/rdata  : dequeue; rdata always shows the head entry
//   full/empty : occupancy flags
// DEPTH must be a power of 2 (>= 2).
module text_buf_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [PW:0]      wp, rp;
   logic             do_push, do_pop;

   assign empty   = (wp == rp);
   assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
   assign rdata   = store[rp[PW-1:0]];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset) store[wp[PW-1:0]] <= wdata;
   end
endmodule

// File: rtl/text_buf_arbiter.sv
// text_buf_arbiter: shares one single-port character RAM between the real-time
// display fetch, a screen-clear sweep and queued keyboard writes.
// Slot priority per cycle: display read > clear write > queued write.
// Optional feature: define TEXTBUF_CLEAR_EN to build the CLEAR state and the
// clr_addr sweep; without it clear_req is ignored and busy is tied low.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   disp_req/disp_addr      : display fetch, served in the same cycle
//   disp_valid/disp_data    : read result one cycle later (data held otherwise)
//   wr_valid/wr_ready       : keyboard write handshake, wr_addr/wr_data payload
//   clear_req/busy          : blank-screen pulse, busy while sweeping
//   mem_en/we/addr/wdata    : RAM access port, mem_rdata returns a cycle later
module text_buf_arbiter
   import text_buf_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int CELLS      = CELLS_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int BLANK      = BLANK_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clear_req,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int                EW      = ADDR_W + DATA_W;
   localparam logic [ADDR_W:0]   CELLS_X = (ADDR_W+1)'(CELLS);
   localparam logic [DATA_W-1:0] BLANK_C = DATA_W'(BLANK);

   state_t              state;
   logic [ADDR_W-1:0]   clr_addr;
   logic                clr_hit;
   logic                push, pop, full, empty;
   logic [EW-1:0]       head;
   logic [ADDR_W-1:0]   head_addr;
   logic [DATA_W-1:0]   head_data;
   logic [DATA_W-1:0]   data_q;

   assign wr_ready = !full && (state == IDLE);
   // A clear pulse flushes the queue, so a write handshaken in the same
   // cycle is discarded rather than surviving the flush.
   assign push = wr_valid && wr_ready && !clr_hit;
   assign {head_addr, head_data} = head;

   text_buf_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (clr_hit),
      .push  (push),
      .wdata ({wr_addr, wr_data}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // RAM slot selection.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      pop       = 1'b0;
      if (disp_req) begin
         mem_en   = 1'b1;
         mem_addr = disp_addr;
      end else if (clr_hit) begin
         // Clear pulse cycle: nothing is written, the sweep starts next cycle.
      end else if (state == CLEAR) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = clr_addr;
         mem_wdata = BLANK_C;
      end else if (!empty) begin
         pop = 1'b1;
         // Off-screen writes are consumed but never reach the RAM.
         if ({1'b0, head_addr} < CELLS_X) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_data;
         end
      end
   end

`ifdef TEXTBUF_CLEAR_EN
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

   assign clr_hit = clear_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         clr_addr <= '0;
         busy     <= 1'b0;
      end else if (clear_req) begin
         state    <= CLEAR;
         clr_addr <= '0;
         busy     <= 1'b1;
      end else if (state == CLEAR && !disp_req) begin
         if (clr_addr == LAST_ADDR) begin
            state    <= IDLE;
            clr_addr <= '0;
            busy     <= 1'b0;
         end else begin
            clr_addr <= clr_addr + 1'b1;
         end
      end
   end
`else
   logic unused_clear;

   assign unused_clear = clear_req;
   assign clr_hit      = 1'b0;
   assign state        = IDLE;
   assign clr_addr     = '0;
   assign busy         = 1'b0;
`endif

   // Read data returns from the RAM one cycle after the request; pass it
   // straight through on that cycle and hold the last value afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_valid <= 1'b0;
         data_q     <= '0;
      end else begin
         disp_valid <= disp_req;
         if (disp_valid) data_q <= mem_rdata;
      end
   end

   assign disp_data = disp_valid ? mem_rdata : data_q;
endmodule

// File: tb/tb_text_buf_arbiter.sv
module tb_text_buf_arbiter;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 6;
   localparam int CELLS  = 2400;
   localparam int DEPTH  = 4;
   localparam int BLANK  = 0;
   localparam int RAMSZ  = 4096;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              disp_req = 1'b1;
   logic [ADDR_W-1:0] disp_addr = '0;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              clear_req = 1'b0;
   logic              busy;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              ram_init = 1'b1;

   always #5 clk = ~clk;

   text_buf_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .clear_req  (clear_req),
      .busy       (busy),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Single-port RAM driven by the DUT.
   logic [DATA_W-1:0] ram [RAMSZ];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < RAMSZ; i++) ram[i] <= DATA_W'(i * 7);
      end else begin
         if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
         if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
      end
   end

   // ---------------- reference model ----------------
   typedef struct { int a; int d; } wr_t;
   wr_t q[$];
   bit  clearing;
   int  cptr;
   bit  prev_disp;
   int  rd_val, last_data;
   int  mram [RAMSZ];

   int  checks = 0, errors = 0;
   bit  seen_en, seen_we;
   int  seen_wa, seen_wd;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic bit clr_now();
`ifdef TEXTBUF_CLEAR_EN
      return clear_req;
`else
      return 1'b0;
`endif
   endfunction

   task automatic compare();
      bit een, ewe;
      int ea, ed;
      if (reset) return;
      een = 0; ewe = 0; ea = 0; ed = 0;
      if (disp_req) begin
         een = 1; ea = disp_addr;
      end else if (clr_now()) begin
      end else if (clearing) begin
         een = 1; ewe = 1; ea = cptr; ed = BLANK;
      end else if (q.size() > 0 && q[0].a < CELLS) begin
         een = 1; ewe = 1; ea = q[0].a; ed = q[0].d;
      end
      chk("mem_en", mem_en, een);
      chk("mem_we", mem_we, ewe);
      chk("mem_addr", mem_addr, ea);
      if (!(een && !ewe)) chk("mem_wdata", mem_wdata, ed);
      chk("wr_ready", wr_ready, (q.size() < DEPTH) && !clearing);
      chk("busy", busy, clearing);
      chk("disp_valid", disp_valid, prev_disp);
      chk("disp_data", disp_data, prev_disp ? rd_val : last_data);
   endtask

   task automatic model_step();
      bit rdy, clr;
      wr_t e;
      if (reset) begin
         q.delete(); clearing = 0; cptr = 0;
         prev_disp = 0; rd_val = 0; last_data = 0;
         return;
      end
      last_data = prev_disp ? rd_val : last_data;
      rdy = (q.size() < DEPTH) && !clearing;
      clr = clr_now();
      if (clr) begin
         q.delete(); clearing = 1; cptr = 0;
      end else if (disp_req) begin
      end else if (clearing) begin
         mram[cptr] = BLANK;
         cptr++;
         if (cptr == CELLS) begin clearing = 0; cptr = 0; end
      end else if (q.size() > 0) begin
         e = q.pop_front();
         if (e.a < CELLS) mram[e.a] = e.d;
      end
      if (wr_valid && rdy && !clr) begin
         e.a = wr_addr; e.d = wr_data;
         q.push_back(e);
      end
      prev_disp = disp_req;
      if (disp_req) rd_val = mram[disp_addr];
   endtask

   task automatic tick();
      @(negedge clk);
      compare();
      seen_en = mem_en; seen_we = mem_we; seen_wa = mem_addr; seen_wd = mem_wdata;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic quiet();
      disp_req = 0; wr_valid = 0; clear_req = 0;
   endtask

   int cnt, cyc, nw, first_a, bad;

   initial begin
      for (int i = 0; i < RAMSZ; i++) mram[i] = (i * 7) % 64;
      q.delete(); clearing = 0; cptr = 0; prev_disp = 0; rd_val = 0; last_data = 0;

      // reset state
      tick();
      ram_init = 0;
      tick();
      reset = 0; quiet(); #1;
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_disp_data", disp_data, 0);
      chk("rst_mem_en", mem_en, 0);

      // read latency: RAM[5] <- 0x2A, then fetch it
      disp_req = 1; wr_valid = 1; wr_addr = 5; wr_data = 6'h2A; tick();
      quiet(); tick();
      chk("wr5_addr", seen_wa, 5);
      disp_req = 1; disp_addr = 5; tick();
      quiet();
      chk("rd_valid", disp_valid, 1);
      chk("rd_data", disp_data, 8'h2A);
      tick();
      chk("rd_valid_off", disp_valid, 0);
      chk("rd_data_hold", disp_data, 8'h2A);

      // priority: display holds the port for 10 cycles with 3 writes queued
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         disp_req = 1; disp_addr = ADDR_W'(i);
         wr_valid = (i < 3); wr_addr = ADDR_W'(100 + i); wr_data = DATA_W'(i + 1);
         tick();
         if (seen_we) cnt++;
      end
      chk("prio_no_we", cnt, 0);
      quiet();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("prio_wr_addr", seen_wa, 100 + i);
         chk("prio_wr_data", seen_wd, i + 1);
      end

      // full: 5 offers back to back while the display blocks draining
      for (int i = 0; i < 5; i++) begin
         disp_req = 1; wr_valid = 1; wr_addr = ADDR_W'(200 + i); wr_data = DATA_W'(10 + i);
         #1;
         chk("full_ready", wr_ready, (i < 4) ? 1 : 0);
         tick();
      end
      quiet(); tick();
      chk("full_pop_frees", wr_ready, 1);
      for (int i = 0; i < 3; i++) tick();

      // off-screen write is popped without a RAM access
      disp_req = 1; wr_valid = 1; wr_addr = 3000; wr_data = 9; tick();
      quiet(); tick();
      chk("drop_en", seen_en, 0);
      tick();
      chk("drop_ready", wr_ready, 1);

`ifdef TEXTBUF_CLEAR_EN
      // reset in the middle of a sweep
      disp_req = 1; clear_req = 1; tick();
      quiet();
      for (int i = 0; i < 50; i++) tick();
      chk("mid_busy", busy, 1);
      reset = 1; disp_req = 1; tick();
      reset = 0; quiet(); #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", wr_ready, 1);
      chk("mid_rst_valid", disp_valid, 0);

      // full clear with no display traffic
      disp_req = 1; clear_req = 1; tick();
      quiet(); cyc = 0;
      while (busy && cyc < 3000) begin tick(); cyc++; end
      chk("clear_busy_cycles", cyc, 2400);
      bad = 0;
      for (int i = 0; i < CELLS; i++) if (ram[i] != DATA_W'(BLANK)) bad++;
      chk("clear_all_blank", bad, 0);

      // flush of queued writes and restart
      for (int i = 0; i < 2; i++) begin
         disp_req = 1; wr_valid = 1; wr_addr = ADDR_W'(300 + i); wr_data = DATA_W'(5 + i);
         tick();
      end
      wr_valid = 0; clear_req = 1; tick();
      quiet();
      for (int i = 0; i < 100; i++) tick();
      chk("flush_q300", ram[300], 0);
      chk("flush_q301", ram[301], 0);
      disp_req = 1; clear_req = 1; tick();
      quiet(); cyc = 0; nw = 0; first_a = -1;
      while (busy && cyc < 3000) begin
         tick(); cyc++;
         if (seen_we) begin
            if (first_a < 0) first_a = seen_wa;
            nw++;
         end
      end
      chk("restart_first_addr", first_a, 0);
      chk("restart_writes", nw, 2400);
`else
      // clear_req has no effect in this build
      disp_req = 1; clear_req = 1; wr_valid = 1; wr_addr = 7; wr_data = 3; tick();
      quiet(); cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy) cnt++;
      end
      chk("noclr_busy", cnt, 0);
      chk("noclr_write_kept", ram[7], 3);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 6000; i++) begin
         disp_req  = $urandom_range(1, 0) == 1;
         disp_addr = ADDR_W'($urandom_range(CELLS - 1, 0));
         wr_valid  = $urandom_range(2, 0) != 0;
         wr_addr   = ($urandom_range(7, 0) == 0) ? ADDR_W'($urandom_range(RAMSZ - 1, CELLS))
                                                 : ADDR_W'($urandom_range(CELLS - 1, 0));
         wr_data   = DATA_W'($urandom_range(63, 0));
         clear_req = 0;
         reset     = 0;
         if ($urandom_range(1499, 0) == 0) begin clear_req = 1; disp_req = 1; end
         if ($urandom_range(2999, 0) == 0) begin reset = 1; disp_req = 1; clear_req = 0; end
         tick();
      end
      reset = 0; quiet();
      for (int i = 0; i < 3000 && (busy || q.size() > 0); i++) tick();

      bad = 0;
      for (int i = 0; i < RAMSZ; i++) if (int'(ram[i]) != mram[i]) bad++;
      chk("ram_contents", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
